mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single main-memory port between the instruction-cache and data-cache miss/fill engines.
- Latches one request at a time, drives the memory handshake, returns the line to the winning cache and pulses its ready.
- Sits below the I/D caches; its ready pulses end their icache_stall/dcache_stall windows seen by the pipeline stages.
- Includes a response watchdog that flags a memory that never acknowledges.

Parameters:
- ADDR_W, 32, byte-address width
- LINE_W, 128, cache-line / memory data width
- TIMEOUT, 255, max cycles mem_req may wait for mem_ack before mem_err sets (1..255)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- ic_req  in  1  I-cache line-fill request, held until ic_ready
- ic_addr  in  ADDR_W  I-cache line address
- ic_ready  out  1  one-cycle pulse: ic_rdata valid
- ic_rdata  out  LINE_W  fill data for I-cache
- dc_req  in  1  D-cache request, held until dc_ready
- dc_we  in  1  1 = writeback, 0 = fill
- dc_addr  in  ADDR_W  D-cache line address
- dc_wdata  in  LINE_W  writeback data
- dc_ready  out  1  one-cycle pulse: D transaction complete
- dc_rdata  out  LINE_W  fill data for D-cache
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  LINE_W  memory write data
- mem_ack  in  1  memory completion, single cycle
- mem_rdata  in  LINE_W  read data, valid with mem_ack
- busy  out  1  1 whenever state != IDLE
- mem_err  out  1  sticky watchdog timeout flag

Behaviour:
- All outputs registered. Reset (async, any state, mid-transaction included) gives: state=IDLE, every output 0, rdata regs 0, wait counter 0, mem_err 0. mem_req drops immediately on reset assertion.
- States: IDLE, GNT_I, GNT_D, RESP_I, RESP_D.
- IDLE: req and addr sampled at the rising edge.
  - dc_req=1 → GNT_D; latch dc_we/dc_addr/dc_wdata into mem_we/mem_addr/mem_wdata; mem_req=1.
  - else ic_req=1 → GNT_I; mem_we=0, mem_addr=ic_addr, mem_wdata=0; mem_req=1.
  - Both high: D wins (fixed priority).
- GNT_x: mem_req/mem_we/mem_addr/mem_wdata held stable; wait counter increments each cycle.
  - mem_ack=1 → RESP_x; mem_req=0; counter cleared; for a read, mem_rdata captured into ic_rdata/dc_rdata.
  - Writeback (mem_we=1): dc_rdata unchanged.
- RESP_x: x_ready=1 for exactly this cycle; then IDLE unconditionally. No arbitration in RESP.
- Requesters drop req on the edge that ends RESP. The IDLE cycle that follows therefore never re-serves the same request.
- Latency: req sampled at edge 0 → mem_req high cycle 1 → ack at cycle k (k≥1) → ready high cycle k+1 → IDLE cycle k+2. Minimum 3 cycles from accept to next accept.
- Watchdog: counter reaches TIMEOUT in GNT_x without ack → mem_err=1 (sticky until reset). Transaction keeps waiting, and a late ack completes normally. Counter saturates at TIMEOUT.
- mem_ack outside GNT_x: ignored, no state change.
- Request changes while granted: ignored. The latched copy is used.
- rdata registers hold their value until the next fill for the same requester.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: round-robin tie-break. A last_grant flag (reset = D) records the last side served. On simultaneous requests in IDLE, the side not in last_grant wins, so the first tie after reset goes to I. Single requests are unaffected.
- Undefined: fixed D-over-I priority as above; no last_grant flop.

Test Plan:
- I fill alone: ic_req=1, ic_addr=0x100, mem_ack 3 cycles after mem_req with mem_rdata=0xA5A5…A5 → mem_addr=0x100, mem_we=0; ic_ready one-cycle pulse; ic_rdata=0xA5A5…A5; busy low again 2 cycles after ack.
- Simultaneous: ic_req and dc_req (dc_we=1, dc_addr=0x200, dc_wdata=0x1234) same edge → D served first (mem_we=1, mem_wdata=0x1234, dc_rdata unchanged), then I. With ARB_RR_EN, I first, then D; a second tie serves D first.
- Back-to-back D fills 0x300, 0x340, ack 1 cycle after mem_req → exactly two mem_req phases, addresses in order, two dc_ready pulses 3 cycles apart, no duplicate service.
- Watchdog: TIMEOUT=4, ack withheld 10 cycles → mem_err=1 after the 4th wait cycle; ack at cycle 10 still produces ready; mem_err stays 1.
- Reset mid GNT_D → mem_req, busy, dc_ready, mem_err immediately 0; next ic_req served normally.
- Stray mem_ack in IDLE → no ready pulse, state unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between the I-cache and D-cache fill engines, one transaction at a time.
// Define ARB_RR_EN for a round-robin tie-break; the default build gives fixed D-over-I priority.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 128,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_ready,
  output logic [LINE_W-1:0] ic_rdata,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic              dc_ready,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              busy,
  output logic              mem_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GNT_I  = 3'd1,
    GNT_D  = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
  localparam logic [7:0] ERR_AT_C  = 8'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                ic_ready_q, ic_ready_d;
  logic                dc_ready_q, dc_ready_d;
  logic [LINE_W-1:0]   ic_rdata_q, ic_rdata_d;
  logic [LINE_W-1:0]   dc_rdata_q, dc_rdata_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                take_d;

`ifdef ARB_RR_EN
  logic                last_d_q, last_d_d;

  // On a tie the side that was not served last wins; last_d_q = 1 means D was served last.
  assign take_d = dc_req & (~ic_req | ~last_d_q);
`else
  assign take_d = dc_req;
`endif

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ic_rdata_d  = ic_rdata_q;
    dc_rdata_d  = dc_rdata_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
`ifdef ARB_RR_EN
    last_d_d    = last_d_q;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (take_d) begin
          state_d     = GNT_D;
          mem_req_d   = 1'b1;
          mem_we_d    = dc_we;
          mem_addr_d  = dc_addr;
          mem_wdata_d = dc_wdata;
`ifdef ARB_RR_EN
          last_d_d    = 1'b1;
`endif
        end else if (ic_req) begin
          state_d     = GNT_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = ic_addr;
          mem_wdata_d = {LINE_W{1'b0}};
`ifdef ARB_RR_EN
          last_d_d    = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      GNT_I, GNT_D: begin
        if (mem_ack) begin
          state_d   = (state_q == GNT_D) ? RESP_D : RESP_I;
          mem_req_d = 1'b0;
          cnt_d     = 8'd0;
          if (state_q == GNT_I) begin
            ic_rdata_d = mem_rdata;
          end else if (!mem_we_q) begin
            dc_rdata_d = mem_rdata;
          end else begin
            dc_rdata_d = dc_rdata_q;
          end
        end else begin
          // The transaction keeps waiting after a timeout; the flag only reports it.
          if (cnt_q != TIMEOUT_C) begin
            cnt_d = cnt_q + 8'd1;
          end else begin
            cnt_d = cnt_q;
          end
          if (cnt_q >= ERR_AT_C) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
        end
      end
      RESP_I, RESP_D: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        cnt_d     = 8'd0;
      end
    endcase

    ic_ready_d = (state_d == RESP_I);
    dc_ready_d = (state_d == RESP_D);
    busy_d     = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {LINE_W{1'b0}};
      ic_ready_q  <= 1'b0;
      dc_ready_q  <= 1'b0;
      ic_rdata_q  <= {LINE_W{1'b0}};
      dc_rdata_q  <= {LINE_W{1'b0}};
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= 8'd0;
`ifdef ARB_RR_EN
      last_d_q    <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ic_ready_q  <= ic_ready_d;
      dc_ready_q  <= dc_ready_d;
      ic_rdata_q  <= ic_rdata_d;
      dc_rdata_q  <= dc_rdata_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
`ifdef ARB_RR_EN
      last_d_q    <= last_d_d;
`endif
    end
  end

  assign ic_ready  = ic_ready_q;
  assign ic_rdata  = ic_rdata_q;
  assign dc_ready  = dc_ready_q;
  assign dc_rdata  = dc_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign mem_err   = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction table plus hand sequences, scoreboard queues checked by a monitor.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 128;
  localparam int TO = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ic_req = 1'b0;
  logic [AW-1:0] ic_addr = '0;
  logic          ic_ready;
  logic [LW-1:0] ic_rdata;
  logic          dc_req = 1'b0;
  logic          dc_we = 1'b0;
  logic [AW-1:0] dc_addr = '0;
  logic [LW-1:0] dc_wdata = '0;
  logic          dc_ready;
  logic [LW-1:0] dc_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [LW-1:0] mem_rdata = '0;
  logic          busy;
  logic          mem_err;

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ready(ic_ready), .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_ready(dc_ready), .dc_rdata(dc_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .mem_err(mem_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } mem_t;

  typedef struct {
    bit            ic;
    bit            dc;
    bit            dwe;
    logic [AW-1:0] ia;
    logic [AW-1:0] da;
    logic [LW-1:0] dwd;
    int            k;
    logic [LW-1:0] rd_i;
    logic [LW-1:0] rd_d;
    bit            first_d;
  } vec_t;

  int checks = 0;
  int passes = 0;

  mem_t          mem_q[$];
  logic [LW-1:0] ic_q[$];
  logic [LW-1:0] dc_q[$];
  logic [LW-1:0] ic_model = '0;
  logic [LW-1:0] dc_model = '0;
  bit            err_model = 1'b0;

  int cyc = 0;
  int dc_last = 0;
  int dc_prev = 0;
  int mem_phases = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic checka(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic checkw(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: compares each new memory phase and each ready pulse against the scoreboard.
  initial begin
    mem_t          m;
    logic [LW-1:0] r;
    logic          mreq_prev = 1'b0;
    logic          icr_prev = 1'b0;
    logic          dcr_prev = 1'b0;
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset) begin
        if (mem_req && !mreq_prev) begin
          mem_phases++;
          check_int("mem_phase_expected", mem_q.size() > 0 ? 1 : 0, 1);
          if (mem_q.size() > 0) begin
            m = mem_q.pop_front();
            check1("mem_we", mem_we, m.we);
            checka("mem_addr", mem_addr, m.addr);
            checkw("mem_wdata", mem_wdata, m.wdata);
          end
        end
        if (ic_ready) begin
          check1("ic_ready_pulse", icr_prev, 1'b0);
          check_int("ic_ready_expected", ic_q.size() > 0 ? 1 : 0, 1);
          if (ic_q.size() > 0) begin
            r = ic_q.pop_front();
            checkw("ic_rdata", ic_rdata, r);
          end
        end
        if (dc_ready) begin
          dc_prev = dc_last;
          dc_last = cyc;
          check1("dc_ready_pulse", dcr_prev, 1'b0);
          check_int("dc_ready_expected", dc_q.size() > 0 ? 1 : 0, 1);
          if (dc_q.size() > 0) begin
            r = dc_q.pop_front();
            checkw("dc_rdata", dc_rdata, r);
          end
        end
      end
      mreq_prev = mem_req;
      icr_prev  = ic_ready;
      dcr_prev  = dc_ready;
    end
  end

  function automatic mem_t mk(input bit d, input vec_t vv);
    mem_t m;
    m.we    = d ? vv.dwe : 1'b0;
    m.addr  = d ? vv.da : vv.ia;
    m.wdata = d ? vv.dwd : '0;
    return m;
  endfunction

  task automatic push(input bit d, input vec_t vv);
    mem_q.push_back(mk(d, vv));
    if (d) begin
      if (!vv.dwe) dc_model = vv.rd_d;
      dc_q.push_back(dc_model);
    end else begin
      ic_model = vv.rd_i;
      ic_q.push_back(ic_model);
    end
  endtask

  // Memory responder for one transaction: ack in cycle k of mem_req, then requester drops req after RESP.
  task automatic serve(input bit d, input int k, input logic [LW-1:0] rd, input mem_t exp);
    int n = 0;
    while (!mem_req && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    check1("mem_req_start", mem_req, 1'b1);
    if (d) begin
      dc_addr  = ~dc_addr;
      dc_wdata = ~dc_wdata;
    end else begin
      ic_addr = ~ic_addr;
    end
    for (int i = 1; i <= k; i++) begin
      if (i > 1) begin
        @(posedge clock); #1;
        check1("mem_req_hold", mem_req, 1'b1);
      end
      check1("mem_err_wait", mem_err, err_model || (i - 1 >= TO));
    end
    checka("mem_addr_at_ack", mem_addr, exp.addr);
    check1("mem_we_at_ack", mem_we, exp.we);
    checkw("mem_wdata_at_ack", mem_wdata, exp.wdata);
    mem_ack   = 1'b1;
    mem_rdata = rd;
    @(posedge clock); #1;
    mem_ack   = 1'b0;
    mem_rdata = {4{32'hDEAD_BEEF}};
    if (k - 1 >= TO) err_model = 1'b1;
    check1("busy_resp", busy, 1'b1);
    check1("mem_req_dropped", mem_req, 1'b0);
    @(posedge clock); #1;
    if (d) dc_req = 1'b0;
    else ic_req = 1'b0;
    check1("busy_idle", busy, 1'b0);
  endtask

  task automatic run_vec(input vec_t vv);
    bit s0, s1;
    int n;
    if (vv.ic) begin
      ic_req  = 1'b1;
      ic_addr = vv.ia;
    end
    if (vv.dc) begin
      dc_req   = 1'b1;
      dc_we    = vv.dwe;
      dc_addr  = vv.da;
      dc_wdata = vv.dwd;
    end
    if (vv.ic && vv.dc) begin
      s0 = vv.first_d;
      s1 = !vv.first_d;
      n  = 2;
    end else begin
      s0 = vv.dc;
      s1 = 1'b0;
      n  = 1;
    end
    push(s0, vv);
    if (n == 2) push(s1, vv);
    serve(s0, vv.k, s0 ? vv.rd_d : vv.rd_i, mk(s0, vv));
    if (n == 2) serve(s1, vv.k, s1 ? vv.rd_d : vv.rd_i, mk(s1, vv));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[5];
    vec_t vv;
    int   ph0;
    int   n;

    vt[0] = '{ic: 1'b1, dc: 1'b1, dwe: 1'b1, ia: 32'h180, da: 32'h200, dwd: 128'h1234, k: 2,
              rd_i: {4{32'hC0DE_0001}}, rd_d: {4{32'hBAD0_BAD0}}, first_d: 1'b1};
`ifdef ARB_RR_EN
    vt[0].first_d = 1'b0;
`endif
    vt[1] = '{ic: 1'b1, dc: 1'b0, dwe: 1'b0, ia: 32'h100, da: 32'h0, dwd: 128'h0, k: 3,
              rd_i: {16{8'hA5}}, rd_d: 128'h0, first_d: 1'b0};
    vt[2] = '{ic: 1'b1, dc: 1'b1, dwe: 1'b0, ia: 32'h1C0, da: 32'h240, dwd: 128'h5555, k: 1,
              rd_i: {4{32'h1111_2222}}, rd_d: {4{32'h3333_4444}}, first_d: 1'b1};
    vt[3] = '{ic: 1'b0, dc: 1'b1, dwe: 1'b0, ia: 32'h0, da: 32'h300, dwd: 128'h0, k: 1,
              rd_i: 128'h0, rd_d: {4{32'h0300_0300}}, first_d: 1'b1};
    vt[4] = '{ic: 1'b0, dc: 1'b1, dwe: 1'b0, ia: 32'h0, da: 32'h340, dwd: 128'h0, k: 1,
              rd_i: 128'h0, rd_d: {4{32'h0340_0340}}, first_d: 1'b1};

    repeat (2) @(posedge clock);
    #1;
    check1("rst_mem_req", mem_req, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_ic_ready", ic_ready, 1'b0);
    check1("rst_dc_ready", dc_ready, 1'b0);
    check1("rst_mem_err", mem_err, 1'b0);
    checka("rst_mem_addr", mem_addr, 32'h0);
    checkw("rst_ic_rdata", ic_rdata, 128'h0);
    checkw("rst_dc_rdata", dc_rdata, 128'h0);
    reset = 1'b0;
    @(posedge clock); #1;

    ph0 = 0;
    for (int v = 0; v < 5; v++) begin
      if (v == 3) ph0 = mem_phases;
      run_vec(vt[v]);
    end
    check_int("b2b_mem_phases", mem_phases - ph0, 2);
    check_int("b2b_ready_spacing", dc_last - dc_prev, 3);
    check1("no_err_after_table", mem_err, 1'b0);

    // Watchdog: ack withheld until cycle 10 of mem_req.
    vv = '{ic: 1'b0, dc: 1'b1, dwe: 1'b0, ia: 32'h0, da: 32'h400, dwd: 128'h77, k: 10,
           rd_i: 128'h0, rd_d: {4{32'h4040_4040}}, first_d: 1'b1};
    run_vec(vv);
    check1("mem_err_sticky", mem_err, 1'b1);
    repeat (2) @(posedge clock);
    #1;
    check1("mem_err_sticky_later", mem_err, 1'b1);

    // Reset in the middle of a D grant.
    dc_req   = 1'b1;
    dc_we    = 1'b0;
    dc_addr  = 32'h500;
    dc_wdata = 128'hABCD;
    mem_q.push_back('{we: 1'b0, addr: 32'h500, wdata: 128'hABCD});
    n = 0;
    while (!mem_req && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    check1("midrst_granted", mem_req, 1'b1);
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check1("midrst_mem_req", mem_req, 1'b0);
    check1("midrst_busy", busy, 1'b0);
    check1("midrst_dc_ready", dc_ready, 1'b0);
    check1("midrst_mem_err", mem_err, 1'b0);
    checkw("midrst_ic_rdata", ic_rdata, 128'h0);
    dc_req    = 1'b0;
    err_model = 1'b0;
    ic_model  = '0;
    dc_model  = '0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    vv = '{ic: 1'b1, dc: 1'b0, dwe: 1'b0, ia: 32'h600, da: 32'h0, dwd: 128'h0, k: 2,
           rd_i: {4{32'h6060_6060}}, rd_d: 128'h0, first_d: 1'b0};
    run_vec(vv);

    // Stray ack while idle.
    mem_ack   = 1'b1;
    mem_rdata = {4{32'hFFFF_0000}};
    @(posedge clock); #1;
    mem_ack = 1'b0;
    @(posedge clock); #1;
    check1("stray_busy", busy, 1'b0);
    check1("stray_mem_req", mem_req, 1'b0);
    check1("stray_ic_ready", ic_ready, 1'b0);
    check1("stray_dc_ready", dc_ready, 1'b0);
    checkw("stray_ic_rdata", ic_rdata, ic_model);
    checkw("stray_dc_rdata", dc_rdata, dc_model);
    repeat (3) @(posedge clock);
    #1;

    check_int("mem_q_drained", mem_q.size(), 0);
    check_int("ic_q_drained", ic_q.size(), 0);
    check_int("dc_q_drained", dc_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
